if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Parametrised next-generation instruction-fetch stage.
- Generates word-addressed fetch requests to instruction memory over a req/gnt/rvalid handshake and tolerates multi-cycle, in-order memory latency.
- Buffers returned instructions in a DEPTH-entry queue and presents a registered (if_pc, if_instruction, if_en) triple to decode.
- Handles pipeline stall, pipeline flush and early branch redirect, discarding stale in-flight responses.

Parameters:
- ADDR_W, 30, word-address width.
- DATA_W, 32, instruction width.
- DEPTH, 4, queue entries and max outstanding requests; power of two, >=2.
- RST_VECTOR, 0, word address fetched first after reset.
- NOP_WORD, 32'h0000_0000, instruction value driven when if_en=0.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch word address.
- imem_gnt  in  1  request accepted this cycle (meaningful only with imem_req=1).
- imem_rvalid  in  1  response valid; responses return in grant order, >=1 cycle after grant.
- imem_rdata  in  DATA_W  response instruction.
- stall  in  1  downstream stall; hold outputs.
- flush  in  1  pipeline flush; redirect to new_pc.
- new_pc  in  ADDR_W  flush target.
- br_taken  in  1  early branch redirect.
- br_addr  in  ADDR_W  branch target.
- if_pc  out  ADDR_W  PC of the presented instruction.
- if_instruction  out  DATA_W  presented instruction.
- if_en  out  1  presented instruction valid.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - Fetch PC = RST_VECTOR.
  - Queue empty; outstanding=0; drop=0.
  - if_pc=RST_VECTOR, if_instruction=NOP_WORD, if_en=0, imem_req=0.
  - Reset asserted mid-operation discards all queue entries and in-flight accounting. Responses arriving after reset for pre-reset grants are not tracked; the memory must be quiesced with reset.
- Redirect: flush=1 selects new_pc; otherwise br_taken=1 selects br_addr. flush has priority when both are asserted. A redirect takes effect regardless of stall. In the redirect cycle:
  - Queue is cleared.
  - drop <= outstanding, minus 1 if an rvalid arrives that cycle.
  - Fetch PC <= target.
  - imem_req=0.
  - Output register <= {target-independent: if_en=0, if_instruction=NOP_WORD}; if_pc holds.
- Request issue:
  - imem_req=1 iff no redirect this cycle and (queue_count + outstanding) < DEPTH.
  - imem_addr = fetch PC.
  - On req&gnt: fetch PC += 1 (wraps modulo 2^ADDR_W); outstanding += 1.
  - The queue entry's PC is captured into a DEPTH-deep PC tag FIFO at grant.
- Response:
  - On rvalid: outstanding -= 1.
  - If drop>0: drop -= 1 and the data and PC tag are discarded.
  - Otherwise: {tag PC, rdata} is pushed to the queue.
  - Simultaneous gnt and rvalid leaves outstanding unchanged.
  - The reservation rule guarantees the queue never overflows. rvalid with outstanding=0 is illegal; the block asserts in simulation.
- Output register (no redirect):
  - stall=1: hold all outputs; queue still accepts responses.
  - stall=0 and queue non-empty: pop head; if_pc/if_instruction <= head; if_en=1.
  - stall=0 and queue empty: if_en=0, if_instruction=NOP_WORD, if_pc holds.
  - Pop and push in the same cycle are both allowed, including when the queue is full.
- Latency:
  - Grant at edge N, rvalid at edge N+L.
  - Entry is queued at edge N+L and presented at edge N+L+1 (no bypass).
- Counters are clog2(DEPTH+1) bits wide. Pointers are clog2(DEPTH) bits and wrap naturally.

Test Plan:
- Reset, then gnt always 1 and rvalid 1 cycle later with rdata=addr+0x100: if_pc sequence 0,1,2,3…; first if_en=1 three edges after rst falls; if_instruction=0x100,0x101,…
- gnt held 0: imem_req stays 1 with addr=0; if_en stays 0 and if_instruction=NOP_WORD.
- rvalid latency 5, DEPTH=4: at most 4 grants issued before the first response; imem_req drops to 0 after the 4th grant.
- stall=1 for 6 cycles during streaming: outputs frozen; queue fills to 4; imem_req=0; on release, PCs continue contiguously with no loss or duplication.
- 3 requests outstanding (addr 8,9,10), then flush with new_pc=0x40: the next 3 rvalids are dropped; the first presented instruction has if_pc=0x40; if_en=0 in the cycle after the flush.
- flush(new_pc=0x80) and br_taken(br_addr=0x20) in the same cycle with stall=1: fetch resumes at 0x80; if_en=0; the queue is cleared.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues word fetches, tolerates in-order memory
// latency, queues returned words and presents a registered triple to decode.
module if_fetch_queue #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RST_VECTOR = '0,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_instruction,
    output logic              if_en
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] tag_mem [DEPTH];
    logic [PW-1:0]     tag_wp, tag_rp;
    logic [ADDR_W-1:0] q_pc [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PW-1:0]     q_wp, q_rp;
    logic [CW-1:0]     q_cnt, outstanding, drop;

    logic              redirect, room, grant, discard, push, pop;
    logic [ADDR_W-1:0] target;

    assign redirect = flush | br_taken;
    assign target = flush ? new_pc : br_addr;
    // Outstanding requests reserve queue slots, so pushes never overflow.
    assign room = ({1'b0, q_cnt} + {1'b0, outstanding}) < (CW + 1)'(DEPTH);
    assign imem_req = !rst && !redirect && room;
    assign imem_addr = fetch_pc;
    assign grant = imem_req && imem_gnt;
    assign discard = imem_rvalid && (drop != '0);
    assign push = imem_rvalid && !discard && !redirect;
    assign pop = !redirect && !stall && (q_cnt != '0);

    always_ff @(posedge clk) begin
        if (grant)
            tag_mem[tag_wp] <= fetch_pc;
        if (push) begin
            q_pc[q_wp] <= tag_mem[tag_rp];
            q_data[q_wp] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RST_VECTOR;
            tag_wp <= '0;
            tag_rp <= '0;
            q_wp <= '0;
            q_rp <= '0;
            q_cnt <= '0;
            outstanding <= '0;
            drop <= '0;
            if_pc <= RST_VECTOR;
            if_instruction <= NOP_WORD;
            if_en <= 1'b0;
        end else begin
            if (grant)
                tag_wp <= tag_wp + PW'(1);
            if (imem_rvalid)
                tag_rp <= tag_rp + PW'(1);
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
            if (redirect) begin
                // Everything still in flight now belongs to the old path.
                fetch_pc <= target;
                drop <= outstanding - CW'(imem_rvalid);
                q_wp <= '0;
                q_rp <= '0;
                q_cnt <= '0;
                if_en <= 1'b0;
                if_instruction <= NOP_WORD;
            end else begin
                if (grant)
                    fetch_pc <= fetch_pc + ADDR_W'(1);
                if (discard)
                    drop <= drop - CW'(1);
                if (push)
                    q_wp <= q_wp + PW'(1);
                if (pop)
                    q_rp <= q_rp + PW'(1);
                q_cnt <= q_cnt + CW'(push) - CW'(pop);
                if (!stall) begin
                    if (pop) begin
                        if_pc <= q_pc[q_rp];
                        if_instruction <= q_data[q_rp];
                        if_en <= 1'b1;
                    end else begin
                        if_en <= 1'b0;
                        if_instruction <= NOP_WORD;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && imem_rvalid)
            assert (outstanding != '0);
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: latency-configurable memory model plus an
// in-order scoreboard of granted PCs checked as decode sees them.
module tb_if_fetch_queue;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam logic [DW-1:0] NOP = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] new_pc = '0;
    logic          br_taken = 1'b0;
    logic [AW-1:0] br_addr = '0;
    logic [AW-1:0] if_pc;
    logic [DW-1:0] if_instruction;
    logic          if_en;

    if_fetch_queue #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(4),
        .RST_VECTOR('0), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .br_taken(br_taken), .br_addr(br_addr),
        .if_pc(if_pc), .if_instruction(if_instruction),
        .if_en(if_en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        int due;
    } pend_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat = 1;
    int grants = 0;
    int rvalids = 0;
    logic gnt_en = 1'b0;
    logic stall_prev = 1'b1;
    logic redir_prev = 1'b0;
    pend_t pend[$];
    logic [AW-1:0] exp_q[$];

    assign imem_gnt = gnt_en;

    // Memory model and scoreboard producer
    always @(posedge clk) begin
        pend_t p;
        cyc++;
        stall_prev = stall;
        redir_prev = flush | br_taken;
        if (imem_rvalid && pend.size() > 0) begin
            void'(pend.pop_front());
            rvalids++;
        end
        if (flush || br_taken)
            exp_q.delete();
        if (imem_req && imem_gnt) begin
            p.addr = imem_addr;
            p.due = cyc + lat;
            pend.push_back(p);
            exp_q.push_back(imem_addr);
            grants++;
        end
        if (rst) begin
            pend.delete();
            exp_q.delete();
            grants = 0;
            rvalids = 0;
        end
    end

    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata = DW'(pend[0].addr) + 32'h100;
        end
    end

    // Scoreboard consumer: a new presentation follows an unstalled edge
    always @(negedge clk) begin
        logic [AW-1:0] e;
        if (!rst) begin
            if (if_en && !stall_prev && !redir_prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL present: unexpected if_pc=%h", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (if_pc !== e || if_instruction !== DW'(e) + 32'h100) begin
                        bad++;
                        $display("FAIL present: got pc=%h ins=%h want pc=%h",
                                 if_pc, if_instruction, e);
                    end
                end
            end else if (!if_en) begin
                total++;
                if (if_instruction !== NOP) begin
                    bad++;
                    $display("FAIL nop: got ins=%h want %h", if_instruction, NOP);
                end
            end
        end
    end

    task automatic do_reset(input int l, input logic g);
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        br_taken = 1'b0;
        lat = l;
        gnt_en = g;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (if_en) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        gnt_en = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (if_en !== 1'b0 || if_pc !== '0 || if_instruction !== NOP) begin
            bad++;
            $display("FAIL reset_out: en=%b pc=%h ins=%h want 0/0/%h",
                     if_en, if_pc, if_instruction, NOP);
        end
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_req: got %b want 0", imem_req);
        end
    endtask

    task automatic test_no_gnt;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (imem_req !== 1'b1 || imem_addr !== '0 || if_en !== 1'b0) begin
                bad++;
                $display("FAIL no_gnt: req=%b addr=%h en=%b want 1/0/0",
                         imem_req, imem_addr, if_en);
            end
        end
    endtask

    task automatic test_stream;
        int first;
        first = 0;
        do_reset(1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (if_en && first == 0) first = i;
        end
        total++;
        if (first != 3) begin
            bad++;
            $display("FAIL first_en: got edge %0d want 3", first);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_latency;
        bit req_chk, rv_chk;
        req_chk = 1'b0;
        rv_chk = 1'b0;
        do_reset(5, 1'b1);
        for (int i = 0; i < 20 && !rv_chk; i++) begin
            @(negedge clk);
            if (grants == 4 && !req_chk) begin
                req_chk = 1'b1;
                total++;
                if (imem_req !== 1'b0) begin
                    bad++;
                    $display("FAIL lat_req: got %b want 0", imem_req);
                end
            end
            if (rvalids > 0) begin
                rv_chk = 1'b1;
                total++;
                if (grants != 4) begin
                    bad++;
                    $display("FAIL lat_grants: got %0d want 4", grants);
                end
            end
        end
        if (!req_chk || !rv_chk) begin
            total++;
            bad++;
            $display("FAIL lat_timeout: req_chk=%b rv_chk=%b want 1/1",
                     req_chk, rv_chk);
        end
        repeat (30) @(negedge clk);
    endtask

    task automatic test_stall;
        logic [AW-1:0] pc0;
        logic [DW-1:0] ins0;
        logic en0;
        lat = 1;
        repeat (12) @(negedge clk);
        pc0 = if_pc;
        ins0 = if_instruction;
        en0 = if_en;
        stall = 1'b1;
        total++;
        if (en0 !== 1'b1) begin
            bad++;
            $display("FAIL stall_pre: en got %b want 1", en0);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (if_pc !== pc0 || if_instruction !== ins0 || if_en !== en0) begin
                bad++;
                $display("FAIL stall_hold: pc=%h ins=%h want %h %h",
                         if_pc, if_instruction, pc0, ins0);
            end
        end
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL stall_full: req got %b want 0", imem_req);
        end
        stall = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_flush;
        bit ok;
        do_reset(1, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (grants == 8) ok = 1'b1;
        end
        lat = 8;
        for (int i = 0; i < 40 && grants < 11; i++)
            @(negedge clk);
        gnt_en = 1'b0;
        total++;
        if (!ok || grants != 11 || imem_addr !== AW'(11)) begin
            bad++;
            $display("FAIL flush_setup: grants=%0d addr=%h want 11 0b",
                     grants, imem_addr);
        end
        @(negedge clk);
        flush = 1'b1;
        new_pc = AW'(32'h40);
        gnt_en = 1'b1;
        lat = 1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (if_en !== 1'b0 || imem_addr !== AW'(32'h40)) begin
            bad++;
            $display("FAIL flush_cycle: en=%b addr=%h want 0 40",
                     if_en, imem_addr);
        end
        wait_en(ok);
        total++;
        if (!ok || if_pc !== AW'(32'h40)) begin
            bad++;
            $display("FAIL flush_first: pc=%h ok=%b want 40", if_pc, ok);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_flush_br;
        logic [AW-1:0] pc_hold;
        bit ok;
        lat = 1;
        gnt_en = 1'b1;
        repeat (10) @(negedge clk);
        stall = 1'b1;
        repeat (2) @(negedge clk);
        pc_hold = if_pc;
        flush = 1'b1;
        new_pc = AW'(32'h80);
        br_taken = 1'b1;
        br_addr = AW'(32'h20);
        @(negedge clk);
        flush = 1'b0;
        br_taken = 1'b0;
        total++;
        if (if_en !== 1'b0 || if_pc !== pc_hold) begin
            bad++;
            $display("FAIL both_out: en=%b pc=%h want 0 %h",
                     if_en, if_pc, pc_hold);
        end
        total++;
        if (imem_addr !== AW'(32'h80)) begin
            bad++;
            $display("FAIL both_addr: got %h want 80", imem_addr);
        end
        repeat (3) @(negedge clk);
        stall = 1'b0;
        wait_en(ok);
        total++;
        if (!ok || if_pc !== AW'(32'h80)) begin
            bad++;
            $display("FAIL both_first: pc=%h ok=%b want 80", if_pc, ok);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_drain;
        gnt_en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && pend.size() == 0) break;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries never presented", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_no_gnt();
        test_stream();
        test_latency();
        test_stall();
        test_flush();
        test_flush_br();
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
